// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 timing constants, lock FSM state type and
//            colour-bar table shared by the VGA timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_h_active      = 640;
    localparam int c_h_fp          = 16;
    localparam int c_h_sync        = 96;
    localparam int c_h_bp          = 48;
    localparam int c_v_active      = 480;
    localparam int c_v_fp          = 10;
    localparam int c_v_sync        = 2;
    localparam int c_v_bp          = 33;
    localparam int c_h_total       = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total       = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_settle_cycles = 1024;
    localparam int c_cnt_w         = 10;
    localparam int c_num_bars      = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lock_state_t;

    // {r,g,b} per bar, bar 0 leftmost: white, yellow, cyan, green,
    // magenta, red, blue, black
    localparam logic [c_num_bars-1:0][2:0] c_bar_rgb = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [c_cnt_w-1:0] x, input int bar_w);
        logic [2:0] sel;
        sel = '0;
        for (int i = 0; i < c_num_bars; i++) begin
            if (int'(x) >= i * bar_w) begin
                sel = 3'(i);
            end
        end
        return c_bar_rgb[sel];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_lock_gate.sv
`default_nettype none
// ============================================================================
// Module   : vga_lock_gate
// Brief    : Waits for PLL lock, requires it to stay high for SETTLE_CYCLES
//            clocks, then asserts a registered run enable until lock drops.
// Revision : 1.0 - initial release
// ============================================================================
module vga_lock_gate
    import vga_timing_pkg::*;
#(
    parameter int SETTLE_CYCLES = c_settle_cycles
)(
    input  logic clk,
    input  logic rst,
    input  logic i_pll_locked,
    output logic o_run_en
);

    localparam int              c_cw   = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(SETTLE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    if (SETTLE_CYCLES < 2) begin : g_settle_check
        $error("vga_lock_gate: SETTLE_CYCLES must be at least 2");
    end

    lock_state_t     r_state;
    lock_state_t     w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [c_cw-1:0] w_cnt_inc;
    logic            r_run_en;

    assign w_cnt_inc = r_cnt + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= WAIT_LOCK;
            r_cnt    <= '0;
            r_run_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run_en <= (w_state_nxt == RUN);
        end
    end

    // The transition fires on the edge where the count reaches its last value.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (i_pll_locked) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!i_pll_locked) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_last) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (!i_pll_locked) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_run_en = r_run_en;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA raster timing on the 25 MHz pixel clock, gated on
//            PLL lock. Define VGA_TIMING_PATTERN_EN to add colour-bar RGB.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE         = c_h_active,
    parameter int H_FP             = c_h_fp,
    parameter int H_SYNC           = c_h_sync,
    parameter int H_BP             = c_h_bp,
    parameter int V_ACTIVE         = c_v_active,
    parameter int V_FP             = c_v_fp,
    parameter int V_SYNC           = c_v_sync,
    parameter int V_BP             = c_v_bp,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int SETTLE_CYCLES    = c_settle_cycles
)(
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [c_cnt_w-1:0] pixel_x,
    output logic [c_cnt_w-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               running
`ifdef VGA_TIMING_PATTERN_EN
    ,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue
`endif
);

    localparam int c_h_tot   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_max_cnt = 1 << c_cnt_w;

    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_h_last = c_cnt_w'(c_h_tot - 1);
    localparam logic [c_cnt_w-1:0] c_v_last = c_cnt_w'(c_v_tot - 1);
    localparam logic [c_cnt_w-1:0] c_h_vis  = c_cnt_w'(H_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_v_vis  = c_cnt_w'(V_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_hs_beg = c_cnt_w'(H_ACTIVE + H_FP);
    localparam logic [c_cnt_w-1:0] c_hs_end = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_cnt_w-1:0] c_vs_beg = c_cnt_w'(V_ACTIVE + V_FP);
    localparam logic [c_cnt_w-1:0] c_vs_end = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic               c_sync_off = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    if (c_h_tot > c_max_cnt) begin : g_h_total_check
        $error("vga_timing_gen: horizontal total exceeds the 10-bit counter");
    end
    if (c_v_tot > c_max_cnt) begin : g_v_total_check
        $error("vga_timing_gen: vertical total exceeds the 10-bit counter");
    end

    logic               w_run_en;
    logic               w_active;
    logic               w_h_last;
    logic               w_video;
    logic               w_hs_on;
    logic               w_vs_on;
    logic [c_cnt_w-1:0] r_h_cnt;
    logic [c_cnt_w-1:0] r_v_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic [c_cnt_w-1:0] r_pixel_x;
    logic [c_cnt_w-1:0] r_pixel_y;
    logic               r_line_start;
    logic               r_frame_start;

    vga_lock_gate #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_lock_gate (
        .clk          (refclk),
        .rst          (rst),
        .i_pll_locked (pll_locked),
        .o_run_en     (w_run_en)
    );

    // Qualifying with the live lock flag clears outputs on the very edge
    // that the gate leaves RUN, rather than one cycle later.
    assign w_active = w_run_en & pll_locked;
    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_video  = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign w_hs_on  = (r_h_cnt >= c_hs_beg) && (r_h_cnt <= c_hs_end);
    assign w_vs_on  = (r_v_cnt >= c_vs_beg) && (r_v_cnt <= c_vs_end);

    always_ff @(posedge refclk) begin
        if (rst || !w_active) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= c_sync_off;
            r_vsync       <= c_sync_off;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + c_one;
            end else begin
                r_h_cnt <= r_h_cnt + c_one;
            end
            r_hsync       <= w_hs_on ? ~c_sync_off : c_sync_off;
            r_vsync       <= w_vs_on ? ~c_sync_off : c_sync_off;
            r_video_on    <= w_video;
            r_pixel_x     <= r_h_cnt;
            r_pixel_y     <= r_v_cnt;
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = w_run_en;

`ifdef VGA_TIMING_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / c_num_bars;

    logic [2:0] w_bar;
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;

    assign w_bar = bar_rgb(r_h_cnt, c_bar_w);

    always_ff @(posedge refclk) begin
        if (rst || !w_active || !w_video) begin
            r_red   <= 8'h00;
            r_green <= 8'h00;
            r_blue  <= 8'h00;
        end else begin
            r_red   <= {8{w_bar[2]}};
            r_green <= {8{w_bar[1]}};
            r_blue  <= {8{w_bar[0]}};
        end
    end

    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen: cycle-tagged expected
//            snapshots plus raster period/width measurements.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Vertical timing shortened (8 lines/frame) so two frames fit a short run;
    // horizontal timing is the 640-pixel default.
    localparam int TB_V_ACTIVE = 4;
    localparam int TB_V_FP     = 1;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BP     = 1;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b1;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic       running;
`ifdef VGA_TIMING_PATTERN_EN
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
`endif

    vga_timing_gen #(
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FP     (TB_V_FP),
        .V_SYNC   (TB_V_SYNC),
        .V_BP     (TB_V_BP)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
`ifdef VGA_TIMING_PATTERN_EN
        ,
        .red         (red),
        .green       (green),
        .blue        (blue)
`endif
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [26:0] vec;
        logic [23:0] rgb;
    } exp_t;

    typedef struct {
        int          k;
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } row_t;

    // Offsets from the first output cycle of a run, expected outputs at each
    row_t rows [21] = '{
        '{0,     0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF},
        '{1,     1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
        '{80,    80,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFF00},
        '{240,   240, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00FF00},
        '{560,   560, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000},
        '{639,   639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000},
        '{640,   640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{655,   655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{656,   656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{751,   751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{752,   752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{799,   799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{800,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF},
        '{3039,  639, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000},
        '{3200,  0,   4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000},
        '{4000,  0,   5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000},
        '{5500,  700, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{5600,  0,   7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000},
        '{6399,  799, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000},
        '{6400,  0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF},
        '{14700, 300, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00FF00}
    };

    exp_t exp_q [$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [26:0] pack(int x, int y, logic hs, logic vs, logic von,
                                         logic ls, logic fs, logic run);
        return {10'(x), 10'(y), hs, vs, von, ls, fs, run};
    endfunction

    function automatic void push(int c, string n, logic [26:0] v, logic [23:0] rgb);
        exp_t e;
        e.cyc  = c;
        e.name = n;
        e.vec  = v;
        e.rgb  = rgb;
        exp_q.push_back(e);
    endfunction

    function automatic void push_rst(int c, string n, logic run);
        push(c, n, pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, run), 24'h000000);
    endfunction

    task automatic chk(string n, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", n, cyc, act, expv);
        end
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // Monitor / scoreboard
    logic [26:0] act_vec;
    int          last_fs = 0;
    int          last_ls = 0;
    int          von_cnt = 0;
    int          h_low   = -1;
    int          v_low   = -1;
    bit          have_fs = 1'b0;
    bit          have_ls = 1'b0;
    logic        prev_hs = 1'b1;
    logic        prev_vs = 1'b1;

    always @(negedge refclk) begin
        act_vec = {pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start, running};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            checks++;
            if (cur.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cyc %0d missed (now %0d)", cur.name, cur.cyc, cyc);
            end else if (act_vec !== cur.vec) begin
                errors++;
                $display("FAIL %s @cyc %0d: got {x,y,hs,vs,von,ls,fs,run}=%h expected %h",
                         cur.name, cyc, act_vec, cur.vec);
            end
`ifdef VGA_TIMING_PATTERN_EN
            checks++;
            if ({red, green, blue} !== cur.rgb) begin
                errors++;
                $display("FAIL %s_rgb @cyc %0d: got %h expected %h", cur.name, cyc, {red, green, blue}, cur.rgb);
            end
`endif
        end

        if (running !== 1'b1) begin
            if (running === 1'b0) begin
                checks++;
                if (act_vec !== pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                    errors++;
                    $display("FAIL idle_outputs @cyc %0d: got %h expected %h", cyc, act_vec,
                             pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                end
            end
            have_fs = 1'b0;
            have_ls = 1'b0;
            h_low   = -1;
            v_low   = -1;
            prev_hs = 1'b1;
            prev_vs = 1'b1;
        end else begin
            if (frame_start) begin
                if (have_fs) begin
                    chk("frame_period", cyc - last_fs, 6400);
                    chk("video_on_per_frame", von_cnt, 2560);
                end
                have_fs = 1'b1;
                last_fs = cyc;
                von_cnt = 0;
            end
            if (video_on) von_cnt++;
            if (line_start) begin
                if (have_ls) chk("line_period", cyc - last_ls, 800);
                have_ls = 1'b1;
                last_ls = cyc;
            end
            if (prev_hs && !hsync) begin
                chk("hsync_start_x", int'(pixel_x), 656);
                h_low = 0;
            end
            if (!hsync && h_low >= 0) h_low++;
            if (!prev_hs && hsync && h_low >= 0) begin
                chk("hsync_width", h_low, 96);
                h_low = -1;
            end
            if (prev_vs && !vsync) begin
                chk("vsync_start_line", int'(pixel_y), 5);
                chk("vsync_start_x", int'(pixel_x), 0);
                v_low = 0;
            end
            if (!vsync && v_low >= 0) v_low++;
            if (!prev_vs && vsync && v_low >= 0) begin
                chk("vsync_width", v_low, 1600);
                v_low = -1;
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
    end

    // Stimulus
    initial begin
        int t0;
        int tdrop;
        int t1;
        int tl;

        rst        = 1'b1;
        pll_locked = 1'b1;
        for (int c = 1; c <= 5; c++) push_rst(c, "reset_hold", 1'b0);
        // rst released after edge 5; running expected 1024 edges later
        push_rst(1028, "pre_run", 1'b0);
        push_rst(1029, "run_rise", 1'b1);
        t0 = 1030;
        for (int i = 0; i < 21; i++) begin
            push(t0 + rows[i].k, $sformatf("raster_k%0d", rows[i].k),
                 pack(rows[i].x, rows[i].y, rows[i].hs, rows[i].vs, rows[i].von,
                      rows[i].ls, rows[i].fs, 1'b1), rows[i].rgb);
        end
        wait_cyc(5);
        rst = 1'b0;

        // One-cycle lock loss at x=300, y=2 of the third frame
        tdrop = t0 + 14700;
        wait_cyc(tdrop);
        pll_locked = 1'b0;
        push_rst(tdrop + 1, "lock_loss", 1'b0);
        wait_cyc(tdrop + 1);
        pll_locked = 1'b1;
        push_rst(tdrop + 1024, "resettle_hold", 1'b0);
        push_rst(tdrop + 1025, "resettle_run", 1'b1);
        t1 = tdrop + 1026;
        push(t1, "restart_first", pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 24'hFFFFFF);

        // Lock loss in RUN, then a glitch at settle count 500
        tl = t1 + 50;
        push(tl, "pre_second_loss", pack(50, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), 24'hFFFFFF);
        wait_cyc(tl);
        pll_locked = 1'b0;
        push_rst(tl + 1, "second_loss", 1'b0);
        push_rst(tl + 1025, "settle_abort_hold", 1'b0);
        push_rst(tl + 1526, "settle_abort_pre", 1'b0);
        push_rst(tl + 1527, "settle_abort_run", 1'b1);
        push(tl + 1528, "settle_abort_first", pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 24'hFFFFFF);
        wait_cyc(tl + 1);
        pll_locked = 1'b1;
        wait_cyc(tl + 502);
        pll_locked = 1'b0;
        wait_cyc(tl + 503);
        pll_locked = 1'b1;

        wait_cyc(tl + 1540);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout at cyc %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
